// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch sequencer for the 8-bit CPU. It holds the program counter,
// reads opcode bytes (and, for the move-const-to-C opcode, one trailing
// immediate byte) from instruction memory over a req/ack handshake, and then
// presents the complete instruction to the control unit over valid/ready.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   mem_req      out  1       memory read request, held until acknowledged
//   mem_addr     out  ADDR_W  read address (equals pc while mem_req=1)
//   mem_ack      in   1       mem_data is valid this cycle
//   mem_data     in   8       read data, sampled only on req && ack
//   inst         out  8       instruction word to the control unit
//   imm          out  8       immediate byte (meaningful for IMM_OPCODE only)
//   inst_valid   out  1       inst/imm hold a complete instruction
//   inst_ready   in   1       control unit consumes the instruction
//   pc_load      in   1       branch request, honoured only on an accepted issue
//   pc_load_val  in   ADDR_W  branch target
//   pc           out  ADDR_W  current program counter
//
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int unsigned        ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [4:0]         IMM_OPCODE = 5'b00010,
    parameter logic [7:0]         NOP_INST   = 8'hF8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [7:0]        inst,
    output logic [7:0]        imm,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ_OP,
        S_REQ_IMM,
        S_ISSUE
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_inst;
    logic [7:0]        r_imm;
    logic              r_mem_req;
    logic              r_inst_valid;

    // Next sequential address; natural ADDR_W-bit overflow gives the
    // all-ones -> 0 wrap.
    logic [ADDR_W-1:0] w_pc_inc;
    // A byte is taken only when a request is outstanding; an ack that
    // arrives while mem_req is low (e.g. a late ack after reset) is dropped.
    logic              w_byte_taken;
    logic              w_op_has_imm;

    assign w_pc_inc     = r_pc + PC_ONE;
    assign w_byte_taken = r_mem_req && mem_ack;
    assign w_op_has_imm = (mem_data[7:3] == IMM_OPCODE);

    // Single FSM block. mem_req and inst_valid are registered alongside the
    // state so that they change on exactly the same edge as the state does.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours, independent of
    // statement order within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_imm        <= 8'h00;
            r_mem_req    <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                // One quiet cycle after reset release; any stray ack from a
                // transaction cut off by reset lands here and is ignored.
                S_IDLE: begin
                    r_state   <= S_REQ_OP;
                    r_mem_req <= 1'b1;
                end

                S_REQ_OP: begin
                    if (w_byte_taken) begin
                        r_inst <= mem_data;
                        r_pc   <= w_pc_inc;
                        if (w_op_has_imm) begin
                            // Keep mem_req high: the immediate byte at the
                            // next address is requested back to back.
                            r_state <= S_REQ_IMM;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_mem_req    <= 1'b0;
                            r_inst_valid <= 1'b1;
                        end
                    end
                end

                S_REQ_IMM: begin
                    if (w_byte_taken) begin
                        r_imm        <= mem_data;
                        r_pc         <= w_pc_inc;
                        r_state      <= S_ISSUE;
                        r_mem_req    <= 1'b0;
                        r_inst_valid <= 1'b1;
                    end
                end

                // inst/imm are frozen here until the control unit accepts.
                // A branch target is only honoured together with acceptance,
                // so the next fetch starts directly at the new pc.
                S_ISSUE: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_mem_req    <= 1'b1;
                        r_state      <= S_REQ_OP;
                        if (pc_load) begin
                            r_pc <= pc_load_val;
                        end
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_mem_req    <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_pc;
    assign inst       = r_inst;
    assign imm        = r_imm;
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Bench for inst_fetch_unit. The bench plays the instruction memory (a 256-byte
// array with a bench-controlled ack) and the control unit (inst_ready, pc_load).
// Directed scenarios compare a packed snapshot of all outputs against
// hand-derived values; the random scenario follows a transaction-level model
// that walks the program array instruction by instruction.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data;
    logic [7:0] inst;
    logic [7:0] imm;
    logic       inst_valid;
    logic       inst_ready = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_val = 8'h00;
    logic [7:0] pc;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    // Snapshot layout: {mem_req, mem_addr, inst, imm, inst_valid, pc}
    logic [33:0] obs;
    logic [33:0] exp_v;

    assign mem_data = mem[mem_addr];
    assign obs      = {mem_req, mem_addr, inst, imm, inst_valid, pc};

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .ADDR_W     (8),
        .RESET_PC   (8'h00),
        .IMM_OPCODE (5'b00010),
        .NOP_INST   (8'hF8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .inst        (inst),
        .imm         (imm),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc          (pc)
    );

    // Pulses reset for one cycle; returns on the falling edge where rst_n
    // is released (the IDLE cycle follows).
    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        pc_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mem[0]     = 8'h18;
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_v = {1'b0, 8'h00, 8'hF8, 8'h00, 1'b0, 8'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_async: got %h expected %h", obs, exp_v);
        end
        // Release with ack held high: the IDLE cycle must ignore it.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {1'b1, 8'h00, 8'hF8, 8'h00, 1'b0, 8'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_first_req: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_single_byte();
        mem[0]     = 8'h18;
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        exp_v = {1'b1, 8'h00, 8'hF8, 8'h00, 1'b0, 8'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL single_req: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {1'b0, 8'h01, 8'h18, 8'h00, 1'b1, 8'h01};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL single_issue: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_immediate();
        mem[0]     = 8'h10;
        mem[1]     = 8'h5A;
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        exp_v = {1'b1, 8'h00, 8'hF8, 8'h00, 1'b0, 8'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL imm_req_op: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {1'b1, 8'h01, 8'h10, 8'h00, 1'b0, 8'h01};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL imm_req_imm: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {1'b0, 8'h02, 8'h10, 8'h5A, 1'b1, 8'h02};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL imm_issue: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {1'b1, 8'h02, 8'h10, 8'h5A, 1'b0, 8'h02};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL imm_valid_one_cycle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_ack_delay();
        mem[0]     = 8'h20;
        mem_ack    = 1'b0;
        inst_ready = 1'b0;
        apply_reset();
        exp_v = {1'b1, 8'h00, 8'hF8, 8'h00, 1'b0, 8'h00};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL ack_wait_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        mem_ack = 1'b1;
        exp_v = {1'b0, 8'h01, 8'h20, 8'h00, 1'b1, 8'h01};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL ack_capture_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_stall();
        mem[0]     = 8'h10;
        mem[1]     = 8'hC3;
        mem[2]     = 8'h20;
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        // Branch requests without acceptance must have no effect.
        pc_load     = 1'b1;
        pc_load_val = 8'h55;
        exp_v = {1'b0, 8'h02, 8'h10, 8'hC3, 1'b1, 8'h02};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        pc_load    = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        exp_v = {1'b1, 8'h02, 8'h10, 8'hC3, 1'b0, 8'h02};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL stall_release: got %h expected %h", obs, exp_v);
        end
        // Non-immediate follow-up keeps the old immediate.
        @(negedge clk);
        exp_v = {1'b0, 8'h03, 8'h20, 8'hC3, 1'b1, 8'h03};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL stall_imm_retained: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_branch();
        mem[0]     = 8'h30;
        mem[8'h40] = 8'h10;
        mem[8'h41] = 8'h77;
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        exp_v = {1'b0, 8'h01, 8'h30, 8'h00, 1'b1, 8'h01};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL branch_pre_issue: got %h expected %h", obs, exp_v);
        end
        inst_ready  = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'h40;
        @(negedge clk);
        exp_v = {1'b1, 8'h40, 8'h30, 8'h00, 1'b0, 8'h40};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL branch_taken: got %h expected %h", obs, exp_v);
        end
        // pc_load during REQ_OP / REQ_IMM is ignored.
        inst_ready  = 1'b0;
        pc_load_val = 8'h99;
        @(negedge clk);
        exp_v = {1'b1, 8'h41, 8'h10, 8'h00, 1'b0, 8'h41};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL branch_ignored_op: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        pc_load = 1'b0;
        exp_v = {1'b0, 8'h42, 8'h10, 8'h77, 1'b1, 8'h42};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL branch_ignored_imm: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_wrap_reset();
        mem[0]     = 8'h28;
        mem[1]     = 8'h12;
        mem[8'hFF] = 8'h10;
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        inst_ready  = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'hFF;
        @(negedge clk);
        inst_ready = 1'b0;
        pc_load    = 1'b0;
        exp_v = {1'b1, 8'hFF, 8'h28, 8'h00, 1'b0, 8'hFF};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL wrap_req_ff: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {1'b1, 8'h00, 8'h10, 8'h00, 1'b0, 8'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL wrap_imm_addr: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        exp_v = {1'b0, 8'h01, 8'h10, 8'h28, 1'b1, 8'h01};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL wrap_issue: got %h expected %h", obs, exp_v);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        exp_v = {1'b1, 8'h02, 8'h12, 8'h28, 1'b0, 8'h02};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL wrap_in_req_imm: got %h expected %h", obs, exp_v);
        end
        // Reset lands mid-cycle while REQ_IMM is waiting.
        #2 rst_n = 1'b0;
        #1;
        exp_v = {1'b0, 8'h00, 8'hF8, 8'h00, 1'b0, 8'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL wrap_mid_reset: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 8'h00, 8'hF8, 8'h00, 1'b0, 8'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL wrap_late_ack: got %h expected %h", obs, exp_v);
        end
    endtask

    // Zero-wait memory, ready tied high: 1-byte op every 2 cycles, 2-byte op
    // every 3 cycles.
    task automatic test_back_to_back();
        logic [6:0] valid_trace;
        mem[0]     = 8'h18;
        mem[1]     = 8'h10;
        mem[2]     = 8'h5A;
        mem[3]     = 8'h20;
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        apply_reset();
        valid_trace = '0;
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            valid_trace[i] = inst_valid;
        end
        checks++;
        if (valid_trace !== 7'b0100101) begin
            errors++; $display("FAIL b2b_valid_pattern: got %b expected %b", valid_trace, 7'b0100101);
        end
        exp_v = {1'b0, 8'h04, 8'h20, 8'h5A, 1'b1, 8'h04};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL b2b_last_issue: got %h expected %h", obs, exp_v);
        end
        inst_ready = 1'b0;
    endtask

    // Random program, random memory latency, random consumer. The model walks
    // the program one instruction at a time: an instruction starts at exp_pc,
    // is 2 bytes long for the immediate opcode, and the next one starts either
    // right after it or at the branch target given when it was accepted.
    task automatic test_random();
        logic [7:0] exp_pc;
        logic [7:0] exp_end;
        logic [7:0] last_imm;
        logic [7:0] op;
        logic [7:0] nxt;
        logic [7:0] fetched;
        logic [7:0] want_addr;
        logic [7:0] b;
        bit         shown;
        int         since_issue;
        int         issues;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) b[7:3] = 5'b00010;
            mem[i] = b;
        end
        mem_ack    = 1'b0;
        inst_ready = 1'b0;
        apply_reset();
        exp_pc      = 8'h00;
        exp_end     = 8'h00;
        last_imm    = 8'h00;
        fetched     = 8'h00;
        shown       = 1'b0;
        since_issue = 0;
        issues      = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (inst_valid && !shown) begin
                op  = mem[exp_pc];
                nxt = exp_pc + 8'd1;
                if (op[7:3] == 5'b00010) begin
                    last_imm = mem[nxt];
                    exp_end  = exp_pc + 8'd2;
                end else begin
                    exp_end  = nxt;
                end
                checks++;
                if ({inst, imm, pc} !== {op, last_imm, exp_end}) begin
                    errors++;
                    $display("FAIL rand_issue_%0d: got inst %h imm %h pc %h expected inst %h imm %h pc %h",
                             issues, inst, imm, pc, op, last_imm, exp_end);
                end
                shown       = 1'b1;
                issues++;
                since_issue = 0;
            end
            if (mem_req) begin
                want_addr = exp_pc + fetched;
                checks++;
                if (mem_addr !== want_addr || inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_req_addr: got addr %h valid %b expected addr %h valid 0",
                             mem_addr, inst_valid, want_addr);
                end
            end
            since_issue++;
            if (since_issue > 200) begin
                checks++;
                errors++;
                $display("FAIL rand_progress: got no issue for %0d cycles expected at most 200", since_issue);
                break;
            end
            mem_ack     = ($urandom_range(0, 1) == 1);
            inst_ready  = ($urandom_range(0, 2) != 0);
            pc_load     = ($urandom_range(0, 3) == 0);
            pc_load_val = 8'($urandom);
            if (mem_req && mem_ack) fetched = fetched + 8'd1;
            if (inst_valid && inst_ready) begin
                exp_pc  = pc_load ? pc_load_val : exp_end;
                fetched = 8'h00;
                shown   = 1'b0;
            end
        end
        checks++;
        if (issues < 100) begin
            errors++; $display("FAIL rand_issue_count: got %0d expected at least 100", issues);
        end
        mem_ack    = 1'b0;
        inst_ready = 1'b0;
        pc_load    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hF8;
        test_reset();
        test_single_byte();
        test_immediate();
        test_ack_delay();
        test_stall();
        test_branch();
        test_wrap_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch sequencer for the 8-bit CPU. It is the producer of the 8-bit instruction word that the control unit decodes.
- Holds the program counter and reads program bytes from instruction memory over a req/ack handshake.
- Fetches a trailing immediate byte for the move-const-to-C opcode.
- Presents each complete instruction to the control unit with a valid/ready handshake.

Parameters:
- ADDR_W, 8, width of program counter and memory address.
- RESET_PC, 0, PC value loaded on reset.
- IMM_OPCODE, 5'b00010, opcode (inst[7:3]) that carries one immediate byte after the opcode byte.
- NOP_INST, 8'hF8, instruction word presented while no valid instruction is held (opcode 11111).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  output  1  memory read request; held high until acknowledged.
- mem_addr  output  ADDR_W  read address; equals pc while mem_req=1.
- mem_ack  input  1  memory has valid mem_data this cycle.
- mem_data  input  8  read data; sampled only when mem_req=1 and mem_ack=1.
- inst  output  8  instruction word to control unit.
- imm  output  8  immediate byte; meaningful only when inst[7:3]==IMM_OPCODE.
- inst_valid  output  1  inst/imm hold a complete instruction.
- inst_ready  input  1  control unit consumes the instruction this cycle.
- pc_load  input  1  branch request; qualified only on an accepted issue (see Behaviour).
- pc_load_val  input  ADDR_W  branch target.
- pc  output  ADDR_W  current program counter.

Behaviour:
- Reset (rst_n=0, async, effective immediately):
  - state=IDLE, pc=RESET_PC, inst=NOP_INST, imm=0, inst_valid=0, mem_req=0, mem_addr=RESET_PC.
- FSM states: IDLE, REQ_OP, REQ_IMM, ISSUE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - One cycle after reset release, then REQ_OP.
- REQ_OP:
  - mem_req=1, mem_addr=pc.
  - On a clock edge with mem_ack=1: inst<=mem_data, pc<=pc+1 (mod 2^ADDR_W, wraps all-ones to 0).
  - Next state is REQ_IMM if mem_data[7:3]==IMM_OPCODE, else ISSUE.
  - If mem_ack=0, stay in REQ_OP with req and addr unchanged.
- REQ_IMM:
  - mem_req=1, mem_addr=pc.
  - On ack: imm<=mem_data, pc<=pc+1 (wrapping), next state ISSUE.
- ISSUE:
  - inst_valid=1, mem_req=0. inst and imm are held stable until accepted.
  - On a clock edge with inst_ready=1: inst_valid<=0, next state REQ_OP.
  - If pc_load=1 on that same edge, pc<=pc_load_val; otherwise pc is unchanged.
- pc_load in any other state or cycle is ignored. No queued branch exists.
- Non-immediate instructions do not modify imm (it retains its last value).
- mem_ack while mem_req=0 is ignored. An ack may arrive in the same cycle mem_req first rises (zero-wait memory).
- Throughput with zero-wait memory and inst_ready tied high:
  - 1-byte instruction: 2 cycles (REQ_OP, ISSUE).
  - 2-byte instruction: 3 cycles.
- Reset mid-transaction drops mem_req asynchronously. A late ack after reset release but before the new REQ_OP is ignored by the IDLE cycle.
- inst_ready asserted outside ISSUE has no effect.
- When inst_valid=0, inst shows the last issued word (NOP_INST after reset). The control unit must qualify with inst_valid.

Test Plan:
- Reset then zero-wait memory holding 0x18 at address 0 (op 00011) -> mem_addr=0 in the first REQ_OP. inst=0x18, inst_valid=1 two cycles after IDLE, pc=1, imm=0.
- Memory {0x10, 0x5A} at 0,1 with inst_ready=1 (op 00010) -> two requests at addresses 0 then 1. Issue shows inst=0x10, imm=0x5A, pc=2, valid for one cycle.
- mem_ack delayed 3 cycles in REQ_OP -> mem_req and mem_addr stay constant for all waiting cycles. inst is captured only on the ack edge and pc increments exactly once.
- inst_ready=0 for 4 cycles in ISSUE -> inst_valid, inst and imm stay stable and mem_req stays 0. Assert ready -> valid falls next edge and a new REQ_OP starts at pc.
- ISSUE accepted with pc_load=1, pc_load_val=0x40 -> next mem_addr=0x40. pc_load=1 pulsed during REQ_OP -> ignored, fetch continues sequentially.
- pc=0xFF fetching 0x10 with immediate at 0x00 -> wrap; immediate read from address 0x00, pc ends at 0x01. Then drive rst_n low mid-REQ_IMM -> mem_req=0 and inst=0xF8 immediately, pc=RESET_PC.
